mrna_lane_sequencer: RTL and testbench
======================================

// Module: mrna_lane_sequencer
// PURPOSE
// Pneumatic control sequencer for one mRNA isolation lane. Drives every valve
// control line of the lane: cell load/vent, push, lysis in/out, 3-phase pump,
// separation, bead, sieve, waste and collect.
// One start pulse runs the fixed protocol load->lyse->mix->bind->sieve->collect.
// Sits directly upstream of the lane's valve array; one instance per lane.
// PARAMETERS
// FILL_CYCLES   1000  cycles spent in each of LOAD and LYSE
// PHASE_CYCLES  50    cycles per pump phase (6 phases = 1 pump round)
// MIX_ROUNDS    20    pump rounds in MIX
// BIND_ROUNDS   10    pump rounds in BIND
// DRAIN_CYCLES  2000  cycles spent in each of SIEVE and COLLECT
// PORTS
// clk            in   1  clock
// rst            in   1  asynchronous reset, active-high
// start          in   1  begin protocol; honoured only in IDLE
// abort          in   1  stop protocol; all valves closed
// cells_in_ctl   out  1  cell inlet valve
// cells_out_ctl  out  1  cell vent valve
// push_ctl       out  1  push-line valve
// lysis_in_ctl   out  1  lysis inlet valve
// lysis_out_ctl  out  1  lysis outlet valve
// beads_ctl      out  1  bead inlet/outlet valves
// sep_ctl        out  1  separation valve
// sieve_ctl      out  1  sieve valve
// waste_ctl      out  1  waste outlet valve
// collect_ctl    out  1  collect outlet valve
// pump           out  3  pump valves {p3,p2,p1}
// busy           out  1  high in every state except IDLE
// done           out  1  one-cycle pulse on normal completion
// aborted        out  1  one-cycle pulse when abort takes effect
// state          out  3  current state encoding (debug)
// BEHAVIOUR
// - Polarity: control bit 1 = pressurised = valve CLOSED; 0 = open.
// - All outputs registered. Reset: all valve ctl=1, pump=3'b111, busy=0,
//   done=0, aborted=0, state=IDLE. Every counter is cleared.
// - States: IDLE=0 LOAD=1 LYSE=2 MIX=3 BIND=4 SIEVE=5 COLLECT=6 DONE=7.
// - Open (=0) per state; every other ctl=1; pump=111 unless stated:
//   LOAD: cells_in, cells_out.  LYSE: lysis_in, lysis_out.
//   MIX: pump sequence.  BIND: sep, beads, pump sequence.
//   SIEVE: push, sieve, waste.  COLLECT: push, sieve, collect.
// - Pump sequence, 6 phases of PHASE_CYCLES each, restarting at phase 0 on
//   entry to MIX and on entry to BIND:
//   101,100,110,010,011,001.
// - Dwell: LOAD/LYSE = FILL_CYCLES; MIX = MIX_ROUNDS*6*PHASE_CYCLES;
//   BIND = BIND_ROUNDS*6*PHASE_CYCLES; SIEVE/COLLECT = DRAIN_CYCLES;
//   DONE = 1 cycle (done=1), then IDLE.
// - Latency: start sampled high in IDLE at edge t -> state/outputs show LOAD
//   after edge t. Each state's first cycle shows its own valve pattern.
// - start outside IDLE is ignored. Start in DONE is ignored.
// - abort, in any state except IDLE: next edge -> IDLE with all ctl=1 and
//   aborted=1 for 1 cycle; done is not asserted.
//   abort in IDLE: no effect, no aborted pulse.
//   Simultaneous start+abort in IDLE: remain IDLE.
//   Abort in DONE: done still pulses, no aborted pulse.
// - Invariants (every cycle): waste_ctl|collect_ctl=1;
//   cells_in_ctl|lysis_in_ctl=1; at most 2 of the 3 pump bits are 0.
// - Counter widths: $clog2 of the largest dwell + 1. Zero-valued parameters
//   are illegal; flag them with an elaboration-time error.
// - Reset mid-protocol: immediate return to the reset values (asynchronous).
// TESTING (FILL=4 PHASE=2 MIX=2 BIND=1 DRAIN=3)
// 1 Reset asserted mid-MIX -> all ctl=1, pump=111, busy=0, state=0 before next edge.
// 2 start pulse in IDLE -> busy for 50 cycles (4+4+24+12+3+3) with the
//   per-state valve patterns above, then 1-cycle done, then IDLE.
// 3 MIX window -> pump=101,101,100,100,110,110,010,010,011,011,001,001, twice.
// 4 abort on cycle 3 of BIND -> next cycle IDLE, aborted=1, done stays 0,
//   all ctl=1.
// 5 start pulses during LYSE and DONE -> ignored; total run length stays 50.
// 6 start+abort together in IDLE -> state 0, no pulses. Invariants checked
//   by assertion throughout all tests.

Source files
------------

// File: rtl/mrna_lane_sequencer_if.sv
// Control and status bundle between a lane sequencer and its host.
// The slave side is the sequencer; the master side drives start/abort.
interface mrna_lane_sequencer_if;
    logic       start;
    logic       abort;
    logic       cells_in_ctl;
    logic       cells_out_ctl;
    logic       push_ctl;
    logic       lysis_in_ctl;
    logic       lysis_out_ctl;
    logic       beads_ctl;
    logic       sep_ctl;
    logic       sieve_ctl;
    logic       waste_ctl;
    logic       collect_ctl;
    logic [2:0] pump;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [2:0] state;

    modport master (
        output start, abort,
        input  cells_in_ctl, cells_out_ctl, push_ctl, lysis_in_ctl, lysis_out_ctl,
               beads_ctl, sep_ctl, sieve_ctl, waste_ctl, collect_ctl,
               pump, busy, done, aborted, state
    );

    modport slave (
        input  start, abort,
        output cells_in_ctl, cells_out_ctl, push_ctl, lysis_in_ctl, lysis_out_ctl,
               beads_ctl, sep_ctl, sieve_ctl, waste_ctl, collect_ctl,
               pump, busy, done, aborted, state
    );
endinterface

// File: rtl/mrna_lane_sequencer.sv
// Pneumatic valve sequencer for one mRNA isolation lane:
// load -> lyse -> mix -> bind -> sieve -> collect, valve bit 1 = closed.
module mrna_lane_sequencer #(
    parameter int unsigned FILL_CYCLES  = 1000,
    parameter int unsigned PHASE_CYCLES = 50,
    parameter int unsigned MIX_ROUNDS   = 20,
    parameter int unsigned BIND_ROUNDS  = 10,
    parameter int unsigned DRAIN_CYCLES = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    mrna_lane_sequencer_if.slave  bus
);
    localparam int unsigned MIX_DWELL  = MIX_ROUNDS * 6 * PHASE_CYCLES;
    localparam int unsigned BIND_DWELL = BIND_ROUNDS * 6 * PHASE_CYCLES;
    localparam int unsigned MAX_A      = (FILL_CYCLES > MIX_DWELL) ? FILL_CYCLES : MIX_DWELL;
    localparam int unsigned MAX_B      = (BIND_DWELL > DRAIN_CYCLES) ? BIND_DWELL : DRAIN_CYCLES;
    localparam int unsigned MAX_DWELL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W      = $clog2(MAX_DWELL + 1);
    localparam int unsigned PH_W       = $clog2(PHASE_CYCLES + 1);

    if (FILL_CYCLES == 0 || PHASE_CYCLES == 0 || MIX_ROUNDS == 0 ||
        BIND_ROUNDS == 0 || DRAIN_CYCLES == 0) begin : g_param_check
        $error("mrna_lane_sequencer: all timing parameters must be non-zero");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_LYSE    = 3'd2,
        S_MIX     = 3'd3,
        S_BIND    = 3'd4,
        S_SIEVE   = 3'd5,
        S_COLLECT = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n, dwell_last;
    logic [PH_W-1:0]   pcnt_q, pcnt_n;
    logic [2:0]        pidx_q, pidx_n;
    logic              abort_take;

    function automatic logic [2:0] pump_of(input logic [2:0] idx);
        case (idx)
            3'd0:    pump_of = 3'b101;
            3'd1:    pump_of = 3'b100;
            3'd2:    pump_of = 3'b110;
            3'd3:    pump_of = 3'b010;
            3'd4:    pump_of = 3'b011;
            3'd5:    pump_of = 3'b001;
            default: pump_of = 3'b111;
        endcase
    endfunction

    // Last count value of the current state's dwell
    always_comb begin
        dwell_last = '0;
        case (state_q)
            S_LOAD, S_LYSE:     dwell_last = CNT_W'(FILL_CYCLES - 1);
            S_MIX:              dwell_last = CNT_W'(MIX_DWELL - 1);
            S_BIND:             dwell_last = CNT_W'(BIND_DWELL - 1);
            S_SIEVE, S_COLLECT: dwell_last = CNT_W'(DRAIN_CYCLES - 1);
            default:            dwell_last = '0;
        endcase
    end

    // Next state; counters fall back to zero on every state change or abort
    always_comb begin
        state_n    = state_q;
        cnt_n      = '0;
        pcnt_n     = '0;
        pidx_n     = '0;
        abort_take = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start && !bus.abort) state_n = S_LOAD;
            S_DONE: state_n = S_IDLE;
            default: begin
                if (bus.abort) begin
                    state_n    = S_IDLE;
                    abort_take = 1'b1;
                end else if (cnt_q == dwell_last) begin
                    state_n = state_t'(3'(state_q) + 3'd1);
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                    if (state_q == S_MIX || state_q == S_BIND) begin
                        if (pcnt_q == PH_W'(PHASE_CYCLES - 1)) begin
                            pidx_n = (pidx_q == 3'd5) ? 3'd0 : pidx_q + 3'd1;
                        end else begin
                            pcnt_n = pcnt_q + PH_W'(1);
                            pidx_n = pidx_q;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            pcnt_q            <= '0;
            pidx_q            <= '0;
            bus.cells_in_ctl  <= 1'b1;
            bus.cells_out_ctl <= 1'b1;
            bus.push_ctl      <= 1'b1;
            bus.lysis_in_ctl  <= 1'b1;
            bus.lysis_out_ctl <= 1'b1;
            bus.beads_ctl     <= 1'b1;
            bus.sep_ctl       <= 1'b1;
            bus.sieve_ctl     <= 1'b1;
            bus.waste_ctl     <= 1'b1;
            bus.collect_ctl   <= 1'b1;
            bus.pump          <= 3'b111;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.aborted       <= 1'b0;
            bus.state         <= 3'd0;
        end else begin
            state_q           <= state_n;
            cnt_q             <= cnt_n;
            pcnt_q            <= pcnt_n;
            pidx_q            <= pidx_n;
            bus.cells_in_ctl  <= !(state_n == S_LOAD);
            bus.cells_out_ctl <= !(state_n == S_LOAD);
            bus.push_ctl      <= !(state_n == S_SIEVE || state_n == S_COLLECT);
            bus.lysis_in_ctl  <= !(state_n == S_LYSE);
            bus.lysis_out_ctl <= !(state_n == S_LYSE);
            bus.beads_ctl     <= !(state_n == S_BIND);
            bus.sep_ctl       <= !(state_n == S_BIND);
            bus.sieve_ctl     <= !(state_n == S_SIEVE || state_n == S_COLLECT);
            bus.waste_ctl     <= !(state_n == S_SIEVE);
            bus.collect_ctl   <= !(state_n == S_COLLECT);
            bus.pump          <= (state_n == S_MIX || state_n == S_BIND) ? pump_of(pidx_n) : 3'b111;
            bus.busy          <= (state_n != S_IDLE);
            bus.done          <= (state_n == S_DONE);
            bus.aborted       <= abort_take;
            bus.state         <= 3'(state_n);
        end
    end
endmodule

// File: tb/tb_mrna_lane_sequencer.sv
// Scoreboard bench for mrna_lane_sequencer with shortened timing parameters.
module tb_mrna_lane_sequencer;
    localparam int FILL  = 4;
    localparam int PHASE = 2;
    localparam int MIXR  = 2;
    localparam int BINDR = 1;
    localparam int DRAIN = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mrna_lane_sequencer_if bus ();

    mrna_lane_sequencer #(
        .FILL_CYCLES (FILL),
        .PHASE_CYCLES(PHASE),
        .MIX_ROUNDS  (MIXR),
        .BIND_ROUNDS (BINDR),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // {state, busy, done, aborted, pump, ctl[9:0]}
    logic [9:0]  ctl;
    logic [18:0] obs;
    assign ctl = {bus.cells_in_ctl, bus.cells_out_ctl, bus.push_ctl, bus.lysis_in_ctl,
                  bus.lysis_out_ctl, bus.beads_ctl, bus.sep_ctl, bus.sieve_ctl,
                  bus.waste_ctl, bus.collect_ctl};
    assign obs = {bus.state, bus.busy, bus.done, bus.aborted, bus.pump, ctl};

    logic [2:0]  pump_tab [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    logic [18:0] exp_q [$];
    logic [18:0] idle_vec;
    assign idle_vec = {3'd0, 1'b0, 1'b0, 1'b0, 3'b111, 10'h3FF};

    function automatic logic [9:0] ctl_for(input int s);
        case (s)
            1:       ctl_for = 10'b0011111111;
            2:       ctl_for = 10'b1110011111;
            4:       ctl_for = 10'b1111100111;
            5:       ctl_for = 10'b1101111001;
            6:       ctl_for = 10'b1101111010;
            default: ctl_for = 10'b1111111111;
        endcase
    endfunction

    function automatic int dwell_for(input int s);
        case (s)
            1, 2:    dwell_for = FILL;
            3:       dwell_for = MIXR * 6 * PHASE;
            4:       dwell_for = BINDR * 6 * PHASE;
            default: dwell_for = DRAIN;
        endcase
    endfunction

    // Expected per-cycle outputs from the first LOAD cycle; abort_j < 0 means normal completion
    task automatic push_protocol(input int abort_j);
        logic [2:0] p;
        exp_q.delete();
        for (int s = 1; s <= 6; s++) begin
            for (int k = 0; k < dwell_for(s); k++) begin
                p = (s == 3 || s == 4) ? pump_tab[(k / PHASE) % 6] : 3'b111;
                exp_q.push_back({3'(s), 1'b1, 1'b0, 1'b0, p, ctl_for(s)});
            end
        end
        if (abort_j >= 0) begin
            while (exp_q.size() > abort_j + 1) void'(exp_q.pop_back());
            exp_q.push_back({3'd0, 1'b0, 1'b0, 1'b1, 3'b111, 10'h3FF});
            exp_q.push_back(idle_vec);
        end else begin
            exp_q.push_back({3'd7, 1'b1, 1'b1, 1'b0, 3'b111, 10'h3FF});
            exp_q.push_back(idle_vec);
            exp_q.push_back(idle_vec);
        end
    endtask

    // Pulse start, then compare every cycle against the scoreboard; extra inputs injected after cycle j
    task automatic run_protocol(input string name, input int start_j1, input int start_j2,
                                input int abort_j);
        logic [18:0] e;
        int j = 0;
        @(negedge clk);
        bus.start = 1'b1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, j, obs, e);
            end
            if (j == start_j1 || j == start_j2) bus.start = 1'b1;
            if (j == abort_j) bus.abort = 1'b1;
            j++;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (obs !== idle_vec) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", obs, idle_vec);
        end
        rst = 1'b0;
    endtask

    task automatic test_protocol();
        push_protocol(-1);
        run_protocol("protocol", -1, -1, -1);
    endtask

    task automatic test_ignored_start();
        push_protocol(-1);
        run_protocol("start_in_lyse_done", 5, 50, -1);
    endtask

    task automatic test_abort_bind();
        push_protocol(34);
        run_protocol("abort_bind", -1, -1, 34);
    endtask

    task automatic test_abort_in_done();
        push_protocol(-1);
        run_protocol("abort_in_done", -1, -1, 50);
    endtask

    task automatic test_reset_mid_mix();
        @(negedge clk);
        bus.start = 1'b1;
        repeat (13) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        checks++;
        if (bus.state !== 3'd3) begin
            errors++;
            $display("FAIL reset_mid_mix_pre: state got %0d expected 3", bus.state);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== idle_vec) begin
            errors++;
            $display("FAIL reset_mid_mix_async: got %b expected %b", obs, idle_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== idle_vec) begin
            errors++;
            $display("FAIL reset_mid_mix_release: got %b expected %b", obs, idle_vec);
        end
    endtask

    task automatic test_idle_start_abort();
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        repeat (2) begin
            @(negedge clk);
            bus.start = 1'b0;
            checks++;
            if (obs !== idle_vec) begin
                errors++;
                $display("FAIL idle_start_abort: got %b expected %b", obs, idle_vec);
            end
        end
        bus.abort = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== idle_vec) begin
            errors++;
            $display("FAIL idle_abort_only: got %b expected %b", obs, idle_vec);
        end
    endtask

    // Safety invariants on every sampled cycle
    always @(negedge clk) begin
        if (!rst) begin
            assert ((bus.waste_ctl | bus.collect_ctl) && (bus.cells_in_ctl | bus.lysis_in_ctl)
                    && ($countones(bus.pump) >= 1))
            else begin
                errors++;
                $display("FAIL invariant: waste=%b collect=%b cells_in=%b lysis_in=%b pump=%b",
                         bus.waste_ctl, bus.collect_ctl, bus.cells_in_ctl, bus.lysis_in_ctl, bus.pump);
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_protocol();
        test_ignored_start();
        test_abort_bind();
        test_abort_in_done();
        test_reset_mid_mix();
        test_idle_start_abort();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
